// File: rtl/rx_pixel_packer.sv
// Thresholds visible pixels to one bit each and packs them MSB-first into bytes
// for the frame-buffer BRAM, generating line/byte addresses without a multiplier.
module rx_pixel_packer #(
    parameter int BYTES_PER_LINE = 72,
    parameter int DEPTH          = 16384,
    parameter int ADDR_W         = 14
) (
    input  logic              O_CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic              FRAME_START,
    input  logic              LINE_START,
    input  logic              O_VISIBLE,
    input  logic [9:0]        VIDEO,
    input  logic [9:0]        THRESHOLD,
    output logic [7:0]        BRAM_DIN,
    output logic [ADDR_W-1:0] BRAM_ADDR,
    output logic              BRAM_WE,
    output logic              OVERFLOW
);

    localparam int BI_W = $clog2(BYTES_PER_LINE + 1);
    localparam logic [ADDR_W:0] BPL_A   = (ADDR_W+1)'(BYTES_PER_LINE);
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
    localparam logic [BI_W-1:0] BPL_I   = BI_W'(BYTES_PER_LINE);

    logic [7:0]      shreg;
    logic [2:0]      cnt;
    logic [BI_W-1:0] byte_idx;
    logic [ADDR_W:0] line_addr;
    logic [ADDR_W:0] next_base;
    logic            vis_d;

    logic            pix_bit;
    logic            sample;
    logic            full;
    logic            flush;
    logic            emit;
    logic [7:0]      emit_byte;
    logic [ADDR_W:0] wr_addr;
    logic            in_bounds;

    // A flushed partial byte keeps its first pixel in bit 7.
    function automatic logic [7:0] left_align(input logic [7:0] bits, input logic [2:0] k);
        return bits << (4'd8 - {1'b0, k});
    endfunction

    function automatic logic [BI_W-1:0] sat_inc(input logic [BI_W-1:0] idx);
        return (idx >= BPL_I) ? BPL_I : idx + BI_W'(1);
    endfunction

    always_comb begin
        pix_bit   = (VIDEO >= THRESHOLD);
        sample    = ENABLE & O_VISIBLE;
        full      = sample & (cnt == 3'd7);
        flush     = ENABLE & vis_d & ~O_VISIBLE & (cnt != 3'd0);
        // Start pulses win over any byte completing in the same cycle.
        emit      = ~(FRAME_START | LINE_START) & (full | flush);
        emit_byte = full ? {shreg[6:0], pix_bit} : left_align(shreg, cnt);
        wr_addr   = line_addr + (ADDR_W+1)'(byte_idx);
        in_bounds = (byte_idx < BPL_I) && (wr_addr < DEPTH_A);
    end

    always_ff @(posedge O_CLK) begin
        if (RESET) begin
            BRAM_DIN  <= '0;
            BRAM_ADDR <= '0;
            BRAM_WE   <= 1'b0;
            OVERFLOW  <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
            byte_idx  <= '0;
            line_addr <= '0;
            next_base <= '0;
            vis_d     <= 1'b0;
        end else begin
            BRAM_WE <= 1'b0;
            vis_d   <= sample;
            if (FRAME_START) begin
                line_addr <= '0;
                next_base <= BPL_A;
                byte_idx  <= '0;
                OVERFLOW  <= 1'b0;
                shreg     <= '0;
                cnt       <= '0;
            end else if (LINE_START) begin
                line_addr <= next_base;
                next_base <= next_base + BPL_A;
                byte_idx  <= '0;
                shreg     <= '0;
                cnt       <= '0;
            end else if (emit) begin
                byte_idx <= sat_inc(byte_idx);
                shreg    <= '0;
                cnt      <= '0;
                if (in_bounds) begin
                    BRAM_WE   <= 1'b1;
                    BRAM_DIN  <= emit_byte;
                    BRAM_ADDR <= wr_addr[ADDR_W-1:0];
                end else begin
                    OVERFLOW <= 1'b1;
                end
            end else if (sample) begin
                shreg <= {shreg[6:0], pix_bit};
                cnt   <= cnt + 3'd1;
            end
        end
    end

endmodule
